// File: rtl/ce_reset_gen.sv
// ce_reset_gen: system reset and clock-enable strobe generator for the ZX48 core.
// It waits for a stable DCM lock and then releases rst_n. A free-running /16
// phase counter produces the 14 MHz, 7 MHz and 3.5 MHz single-cycle enables.
// A pause request freezes only the CPU (3.5 MHz) strobes, and only at a period
// boundary, so the CPU never sees a rising-phase strobe without its falling one.
module ce_reset_gen #(
    parameter int HOLD = 1024,
    parameter int SYNC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic locked,
    input  logic pause,
    output logic rst_n,
    output logic ready,
    output logic ce14,
    output logic pe7,
    output logic ne7,
    output logic pe3m5,
    output logic ne3m5,
    output logic paused
);

    localparam int              HW     = $clog2(HOLD + 1);
    localparam logic [HW-1:0]   HOLD_V = HW'(HOLD);

    logic [SYNC-1:0] sync_reg;
    logic [SYNC-1:0] sync_next;
    logic            ls;
    logic [HW-1:0]   hold_reg;
    logic            rst_n_reg;
    logic [3:0]      phase_reg;
    logic            ce14_reg;
    logic            pe7_reg;
    logic            ne7_reg;
    logic            pe3m5_reg;
    logic            ne3m5_reg;
    logic            paused_reg;

    // The shift path of the synchronizer: stage 0 takes the raw flag, each
    // later stage takes the one before it.
    assign sync_next[0] = locked;
    generate
        for (genvar gi = 1; gi < SYNC; gi++) begin : g_sync
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    assign ls = sync_reg[SYNC-1];

    // Bring the asynchronous lock flag into the clock domain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // Hold off rst_n until the lock has been stable for HOLD cycles; any
    // lock loss restarts the wait and re-asserts reset immediately.
    always_ff @(posedge clock) begin
        if (!reset || !ls) begin
            hold_reg  <= '0;
            rst_n_reg <= 1'b0;
        end else if (hold_reg < HOLD_V) begin
            hold_reg  <= hold_reg + 1'b1;
        end else begin
            rst_n_reg <= 1'b1;
        end
    end

    // Phase counter, strobe decode and pause latch. Lock loss clears this
    // state on the same edge that rst_n falls, so strobes stop at once.
    always_ff @(posedge clock) begin
        if (!reset || !ls || !rst_n_reg) begin
            phase_reg  <= 4'd0;
            ce14_reg   <= 1'b0;
            pe7_reg    <= 1'b0;
            ne7_reg    <= 1'b0;
            pe3m5_reg  <= 1'b0;
            ne3m5_reg  <= 1'b0;
            paused_reg <= 1'b0;
        end else begin
            phase_reg <= phase_reg + 4'd1;
            ce14_reg  <= (phase_reg[1:0] == 2'b11);
            pe7_reg   <= (phase_reg[2:0] == 3'b011);
            ne7_reg   <= (phase_reg[2:0] == 3'b111);
            pe3m5_reg <= (phase_reg == 4'b0111) && !paused_reg;
            // The boundary's own ne3m5 uses the old latch value, so a
            // started CPU period always completes.
            ne3m5_reg <= (phase_reg == 4'b1111) && !paused_reg;
            if (phase_reg == 4'b1111) begin
                paused_reg <= pause;
            end
        end
    end

    assign rst_n  = rst_n_reg;
    assign ready  = rst_n_reg & ~paused_reg;
    assign ce14   = ce14_reg;
    assign pe7    = pe7_reg;
    assign ne7    = ne7_reg;
    assign pe3m5  = pe3m5_reg;
    assign ne3m5  = ne3m5_reg;
    assign paused = paused_reg;

endmodule

// File: tb/tb_ce_reset_gen.sv
// Directed bench for ce_reset_gen with HOLD=16, SYNC=2: release timing,
// strobe rates, pause/unpause at period boundaries, lock glitch, mid-run reset.
module tb_ce_reset_gen;

    logic clock = 1'b0;
    logic reset;
    logic locked;
    logic pause;
    logic rst_n, ready, ce14, pe7, ne7, pe3m5, ne3m5, paused;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    ce_reset_gen #(.HOLD(16), .SYNC(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .locked (locked),
        .pause  (pause),
        .rst_n  (rst_n),
        .ready  (ready),
        .ce14   (ce14),
        .pe7    (pe7),
        .ne7    (ne7),
        .pe3m5  (pe3m5),
        .ne3m5  (ne3m5),
        .paused (paused)
    );

    assign outs = {rst_n, ready, ce14, pe7, ne7, pe3m5, ne3m5, paused};

    always #5 clock = ~clock;

    // Advance one edge and settle past it; inputs are driven here too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_release();
        int bad;
        reset = 1'b0; locked = 1'b1; pause = 1'b0;
        repeat (4) tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", outs, 8'h00);
        end
        reset = 1'b1;
        bad = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (rst_n !== 1'b0 || outs !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_n_early got %0d bad edges want 0", bad);
        end
        tick();
        checks++;
        if (outs !== 8'b1100_0000) begin
            errors++;
            $display("FAIL release_edge19 got %b want %b", outs, 8'b1100_0000);
        end
        $display("test_reset_release done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_rates();
        int n_ce14 = 0, n_pe7 = 0, n_ne7 = 0, n_pe3 = 0, n_ne3 = 0;
        int first_ce14 = -1, last_pe7 = -100, last_pe3 = -100;
        int bad_space = 0, bad_ready = 0;
        for (int i = 1; i <= 160; i++) begin
            tick();
            if (ce14) begin n_ce14++; if (first_ce14 < 0) first_ce14 = i; end
            if (pe7)  begin n_pe7++; last_pe7 = i; end
            if (ne7)  begin n_ne7++; if (i - last_pe7 != 4) bad_space++; end
            if (pe3m5) begin n_pe3++; last_pe3 = i; end
            if (ne3m5) begin n_ne3++; if (i - last_pe3 != 8) bad_space++; end
            if (ready !== 1'b1) bad_ready++;
        end
        checks++;
        if (first_ce14 != 4) begin
            errors++;
            $display("FAIL first_ce14 got %0d want 4", first_ce14);
        end
        checks++;
        if (n_ce14 != 40 || n_pe7 != 20 || n_ne7 != 20 || n_pe3 != 10 || n_ne3 != 10) begin
            errors++;
            $display("FAIL rate_counts got %0d/%0d/%0d/%0d/%0d want 40/20/20/10/10",
                     n_ce14, n_pe7, n_ne7, n_pe3, n_ne3);
        end
        checks++;
        if (bad_space != 0) begin
            errors++;
            $display("FAIL strobe_spacing got %0d bad want 0", bad_space);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL ready_running got %0d bad want 0", bad_ready);
        end
        $display("test_rates done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_pause();
        int found = 0, bad = 0;
        int n_cpu = 0, n_ce14 = 0, n_pe7 = 0, n_ne7 = 0;
        for (int i = 0; i < 32 && found == 0; i++) begin
            tick();
            if (pe3m5) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL pause_find_pe3m5 got timeout want pe3m5");
        end
        repeat (2) tick();
        pause = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (ne3m5 !== 1'b0 || paused !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_pre_boundary got %0d bad want 0", bad);
        end
        tick();
        checks++;
        if ({ne3m5, paused, ready} !== 3'b110) begin
            errors++;
            $display("FAIL pause_boundary got %b want 110", {ne3m5, paused, ready});
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            n_cpu  += int'(pe3m5) + int'(ne3m5);
            n_ce14 += int'(ce14);
            n_pe7  += int'(pe7);
            n_ne7  += int'(ne7);
        end
        checks++;
        if (n_cpu != 0 || n_ce14 != 8 || n_pe7 != 4 || n_ne7 != 4) begin
            errors++;
            $display("FAIL paused_strobes got cpu=%0d ce14=%0d pe7=%0d ne7=%0d want 0/8/4/4",
                     n_cpu, n_ce14, n_pe7, n_ne7);
        end
        $display("test_pause done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_unpause();
        int bad = 0;
        repeat (5) tick();
        pause = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (paused !== 1'b1 || pe3m5 !== 1'b0 || ne3m5 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL unpause_hold got %0d bad want 0", bad);
        end
        tick();
        checks++;
        if ({paused, ne3m5, ready} !== 3'b001) begin
            errors++;
            $display("FAIL unpause_boundary got %b want 001", {paused, ne3m5, ready});
        end
        bad = 0;
        for (int k = 12; k <= 19; k++) begin
            tick();
            if (pe3m5 !== (k == 19)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL unpause_first_pe3m5 got %0d bad edges want 0", bad);
        end
        $display("test_unpause done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_lock_glitch();
        int bad = 0;
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        checks++;
        if (rst_n !== 1'b1) begin
            errors++;
            $display("FAIL glitch_edge2 got rst_n=%b want 1", rst_n);
        end
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL glitch_edge3 got %b want %b", outs, 8'h00);
        end
        for (int k = 4; k <= 19; k++) begin
            tick();
            if (outs !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_hold got %0d bad edges want 0", bad);
        end
        tick();
        checks++;
        if (outs !== 8'b1100_0000) begin
            errors++;
            $display("FAIL glitch_release got %b want %b", outs, 8'b1100_0000);
        end
        bad = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (ce14 !== (k == 4)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_first_ce14 got %0d bad edges want 0", bad);
        end
        $display("test_lock_glitch done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_midrun();
        int found = 0, bad = 0;
        pause = 1'b1;
        for (int i = 0; i < 32 && found == 0; i++) begin
            tick();
            if (paused) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL midrun_latch got timeout want paused=1");
        end
        reset = 1'b0;
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset got %b want %b", outs, 8'h00);
        end
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (rst_n !== 1'b0 || paused !== 1'b0) bad++;
        end
        tick();
        checks++;
        if (bad != 0 || rst_n !== 1'b1 || paused !== 1'b0) begin
            errors++;
            $display("FAIL midrun_release got bad=%0d rst_n=%b paused=%b want 0/1/0",
                     bad, rst_n, paused);
        end
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (paused !== (k == 16) || ready !== (k != 16)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrun_relatch got %0d bad edges want 0", bad);
        end
        $display("test_reset_midrun done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        reset = 1'b0; locked = 1'b0; pause = 1'b0;
        test_reset_release();
        test_rates();
        test_pause();
        test_unpause();
        test_lock_glitch();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
